// File: rtl/lsu_wbck_dly_fifo_pkg.sv
// Shared types for the LSU write-back delay buffer: flag layout and bundle width helper.
// The bundle layout {wdat, itag, badaddr, flags} is also what the checker-side comparator unpacks.
package lsu_wbck_dly_fifo_pkg;

  localparam int DLY_AGE_W = 4;

  typedef struct packed {
    logic err;
    logic cmt_ld;
    logic cmt_st;
    logic buserr;
  } wbck_flags_t;

  localparam int WBCK_FLAGS_W = $bits(wbck_flags_t);

  function automatic int bndl_w(input int xlen, input int itag_w, input int addr_w);
    return xlen + itag_w + addr_w + WBCK_FLAGS_W;
  endfunction

endpackage

// File: rtl/lsu_dly_age_ctr.sv
// Per-entry age counter: clears on write, counts while enabled, saturates at MIN_DLY.
// done is registered-state only; no backpressure, clr wins over en.
module lsu_dly_age_ctr #(
  parameter int MIN_DLY = 2,
  parameter int AGE_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(MIN_DLY);
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

  logic [AGE_W-1:0] age;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (en && (age != AGE_SAT)) begin
      age <= age + AGE_ONE;
    end
  end

  assign done = (age >= AGE_SAT);

endmodule

// File: rtl/lsu_wbck_dly_fifo.sv
// Time-shift FIFO for LSU write-back bundles; head presented once aged MIN_DLY (push t -> o_valid t+1+MIN_DLY).
// i_ready = ~full from registered pointers; push while full is dropped and sets sticky ovf_err.
module lsu_wbck_dly_fifo
  import lsu_wbck_dly_fifo_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MIN_DLY = 2,
  parameter int XLEN    = 32,
  parameter int ITAG_W  = 1,
  parameter int ADDR_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [XLEN-1:0]          i_wdat,
  input  logic [ITAG_W-1:0]        i_itag,
  input  logic                     i_err,
  input  logic                     i_cmt_ld,
  input  logic                     i_cmt_st,
  input  logic [ADDR_W-1:0]        i_badaddr,
  input  logic                     i_buserr,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [XLEN-1:0]          o_wdat,
  output logic [ITAG_W-1:0]        o_itag,
  output logic                     o_err,
  output logic                     o_cmt_ld,
  output logic                     o_cmt_st,
  output logic [ADDR_W-1:0]        o_badaddr,
  output logic                     o_buserr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     lsu_active,
  output logic                     ovf_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BNDL_W = bndl_w(XLEN, ITAG_W, ADDR_W);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [BNDL_W-1:0] ram [DEPTH];
  logic [BNDL_W-1:0] wr_bndl;
  logic [BNDL_W-1:0] rd_bndl;
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [DEPTH-1:0]  age_done;
  logic              full;
  logic              push;
  logic              pop;
  wbck_flags_t       in_flags;
  wbck_flags_t       out_flags;

  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign i_ready = ~full;
  assign o_valid = (count_q != '0) && age_done[rd_ptr[PTR_W-1:0]];

  // flush dominates: neither a push nor a pop takes effect in a flush cycle
  assign push = i_valid && i_ready && !flush;
  assign pop  = o_valid && o_ready && !flush;

  assign in_flags = '{err: i_err, cmt_ld: i_cmt_ld, cmt_st: i_cmt_st, buserr: i_buserr};
  assign wr_bndl  = {i_wdat, i_itag, i_badaddr, in_flags};
  assign rd_bndl  = ram[rd_ptr[PTR_W-1:0]];
  assign {o_wdat, o_itag, o_badaddr, out_flags} = rd_bndl;
  assign o_err    = out_flags.err;
  assign o_cmt_ld = out_flags.cmt_ld;
  assign o_cmt_st = out_flags.cmt_st;
  assign o_buserr = out_flags.buserr;

  assign count      = count_q;
  assign lsu_active = (count_q != '0) || i_valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [PTR_W-1:0] rel_idx;
    logic             occupied;

    // slot g is live when its distance from the head is below the occupancy
    assign rel_idx  = PTR_W'(g) - rd_ptr[PTR_W-1:0];
    assign occupied = ({1'b0, rel_idx} < count_q);

    lsu_dly_age_ctr #(
      .MIN_DLY (MIN_DLY),
      .AGE_W   (DLY_AGE_W)
    ) u_age (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (push && (wr_ptr[PTR_W-1:0] == PTR_W'(g))),
      .en    (occupied),
      .done  (age_done[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (i_valid && !i_ready) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr[PTR_W-1:0]] <= wr_bndl;
  end

endmodule

// File: tb/tb_lsu_wbck_dly_fifo.sv
// Randomised and directed bench for lsu_wbck_dly_fifo against a timestamped-queue reference model.
`timescale 1ns/1ps
module tb_lsu_wbck_dly_fifo;

  localparam int DEPTH   = 4;
  localparam int MIN_DLY = 2;
  localparam int XLEN    = 32;
  localparam int ITAG_W  = 1;
  localparam int ADDR_W  = 32;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int BW      = XLEN + ITAG_W + ADDR_W + 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [XLEN-1:0]   i_wdat = '0;
  logic [ITAG_W-1:0] i_itag = '0;
  logic              i_err = 1'b0;
  logic              i_cmt_ld = 1'b0;
  logic              i_cmt_st = 1'b0;
  logic [ADDR_W-1:0] i_badaddr = '0;
  logic              i_buserr = 1'b0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [XLEN-1:0]   o_wdat;
  logic [ITAG_W-1:0] o_itag;
  logic              o_err;
  logic              o_cmt_ld;
  logic              o_cmt_st;
  logic [ADDR_W-1:0] o_badaddr;
  logic              o_buserr;
  logic [CW-1:0]     count;
  logic              lsu_active;
  logic              ovf_err;

  lsu_wbck_dly_fifo #(
    .DEPTH(DEPTH), .MIN_DLY(MIN_DLY), .XLEN(XLEN), .ITAG_W(ITAG_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_wdat(i_wdat), .i_itag(i_itag),
    .i_err(i_err), .i_cmt_ld(i_cmt_ld), .i_cmt_st(i_cmt_st),
    .i_badaddr(i_badaddr), .i_buserr(i_buserr),
    .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_itag(o_itag),
    .o_err(o_err), .o_cmt_ld(o_cmt_ld), .o_cmt_st(o_cmt_st),
    .o_badaddr(o_badaddr), .o_buserr(o_buserr),
    .count(count), .lsu_active(lsu_active), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst_n) chk_en <= 1'b1;

  // reference model: accepted bundles in order, each tagged with the cycle it becomes presentable
  typedef struct {
    logic [BW-1:0] b;
    int            rdy;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_hs  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] in_b();
    return {i_wdat, i_itag, i_badaddr, i_err, i_cmt_ld, i_cmt_st, i_buserr};
  endfunction

  function automatic logic [BW-1:0] out_b();
    return {o_wdat, o_itag, o_badaddr, o_err, o_cmt_ld, o_cmt_st, o_buserr};
  endfunction

  always @(negedge clk) begin : monitor
    bit   ev;
    bit   full_m;
    ent_t e;
    if (chk_en) begin
      ev = (mq.size() != 0) && (cyc >= mq[0].rdy);
      chk("o_valid", o_valid, ev);
      chk("i_ready", i_ready, mq.size() < DEPTH);
      chk("count", count, mq.size());
      chk("ovf_err", ovf_err, m_ovf);
      chk("lsu_active", lsu_active, (mq.size() != 0) || i_valid);
      if (ev && o_valid) chk("o_bundle", out_b(), mq[0].b);
      if (o_valid && o_ready && rst_n && !flush) n_hs++;
      full_m = (mq.size() >= DEPTH);
      if (!rst_n || flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        if (ev && o_ready) void'(mq.pop_front());
        if (i_valid) begin
          if (full_m) begin
            m_ovf = 1'b1;
          end else begin
            e.b   = in_b();
            e.rdy = cyc + 1 + MIN_DLY;
            mq.push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bndl();
    i_wdat    = $urandom;
    i_itag    = ITAG_W'($urandom);
    i_badaddr = $urandom;
    {i_err, i_cmt_ld, i_cmt_st, i_buserr} = 4'($urandom);
  endtask

  // expects an empty buffer; bounded wait for the single bundle to surface
  task automatic push_and_time(input string nm, input logic [31:0] d);
    int t0;
    int lat;
    bit seen;
    o_ready = 1'b1;
    rand_bndl();
    i_wdat  = d;
    i_valid = 1'b1;
    t0 = cyc;
    tick();
    i_valid = 1'b0;
    lat  = -1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (o_valid) begin
        seen = 1'b1;
        lat  = cyc - t0;
        chk({nm, "_data"}, o_wdat, d);
      end
    end
    chk(nm, lat, 1 + MIN_DLY);
    @(posedge clk);
    #1;
  endtask

  int hs0;

  initial begin
    // reset held with a bundle offered
    rst_n   = 1'b0;
    i_valid = 1'b1;
    rand_bndl();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_i_ready", i_ready, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf_err, 1'b0);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    tick();
    tick();

    push_and_time("latency", 32'hDEAD_BEEF);
    tick();

    // fill with the sink stalled; fifth bundle overflows
    o_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_bndl();
      i_itag  = ITAG_W'(i % 2);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    chk("fill_ovf", ovf_err, 1'b1);
    chk("fill_i_ready", i_ready, 1'b0);
    hs0 = n_hs;
    o_ready = 1'b1;
    repeat (10) tick();
    chk("fill_pops", n_hs - hs0, 4);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clr_ovf", ovf_err, 1'b0);

    // back-to-back stream, 25 pointer wraps
    hs0 = n_hs;
    o_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_bndl();
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    repeat (6) tick();
    chk("stream_pops", n_hs - hs0, 100);
    chk("stream_ovf", ovf_err, 1'b0);

    // flush with a simultaneous push while three entries are held
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bndl();
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    repeat (4) tick();
    rand_bndl();
    flush   = 1'b1;
    i_valid = 1'b1;
    tick();
    flush   = 1'b0;
    i_valid = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_o_valid", o_valid, 1'b0);
    chk("flush_ovf", ovf_err, 1'b0);
    push_and_time("post_flush_latency", 32'h1234_5678);
    tick();

    // reset while two entries are ageing
    o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_bndl();
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_i_ready", i_ready, 1'b1);
    chk("midrst_o_valid", o_valid, 1'b0);
    hs0 = n_hs;
    o_ready = 1'b1;
    repeat (8) tick();
    chk("midrst_no_stale", n_hs - hs0, 0);

    // random traffic with occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      rand_bndl();
      i_valid = ($urandom_range(3, 0) != 0);
      o_ready = ($urandom_range(2, 0) != 0);
      flush   = ($urandom_range(63, 0) == 0);
      rst_n   = ($urandom_range(299, 0) != 0);
      tick();
    end
    flush   = 1'b0;
    rst_n   = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (10) tick();
    chk("drain_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
